// File: rtl/rps_pkg.sv
// Shared constants and types for the rock-paper-scissors round controller:
// move and verdict encodings, controller state enum, score width.
package rps_pkg;

  localparam int unsigned SCORE_W = 4;

  // Moves are one-hot-cold: the single 0 bit names the move.
  localparam logic [2:0] MOVE_ROCK     = 3'b110;
  localparam logic [2:0] MOVE_PAPER    = 3'b101;
  localparam logic [2:0] MOVE_SCISSORS = 3'b011;
  localparam logic [2:0] MOVE_NONE     = 3'b111;

  localparam logic [2:0] VERD_P1_WIN  = 3'b000;
  localparam logic [2:0] VERD_P2_WIN  = 3'b001;
  localparam logic [2:0] VERD_TIE     = 3'b010;
  localparam logic [2:0] VERD_INVALID = 3'b100;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EVAL = 2'd1,
    ST_SHOW = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // Any verdict code outside the three legal outcomes collapses to INVALID.
  function automatic logic [2:0] norm_verdict(input logic [2:0] v);
    logic [2:0] r;
    r = VERD_INVALID;
    if (v == VERD_P1_WIN || v == VERD_P2_WIN || v == VERD_TIE) r = v;
    return r;
  endfunction

endpackage

// File: rtl/rps_hold_timer.sv
// Loadable down-counter. done_o flags the terminal count (value 1), i.e. the
// last cycle of a loaded interval while enabled; the owner gates it by state.
module rps_hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement; stalls at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                     cnt_d = '0;
    else if (load_i)                 cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: hides locked moves, presents them to
// the external judge for one EVAL cycle, registers the verdict, keeps score.
// Optional lock timeout (forfeit win) is built when RPS_LOCK_TIMEOUT_EN is
// defined; otherwise WAIT waits forever and forfeit is tied low.
//
// state | meaning
// WAIT  | collecting locks, moves hidden (NONE driven)
// EVAL  | one cycle, captured moves on the judge, verdict sampled
// SHOW  | result held SHOW_CYCLES cycles, moves displayed
// OVER  | a player reached WIN_SCORE, waiting for new_game
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 3,
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         p1_sel,
  input  logic [2:0]         p2_sel,
  input  logic               p1_lock,
  input  logic               p2_lock,
  input  logic               new_game,
  input  logic [2:0]         judge_y,
  output logic [2:0]         p1_move,
  output logic [2:0]         p2_move,
  output logic [2:0]         last_result,
  output logic               result_valid,
  output logic               forfeit,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round_cnt,
  output logic               game_over,
  output logic [1:0]         state_o
);

  // One counter serves both the show hold and the lock timeout, so it is
  // sized for the longer of the two intervals.
  localparam int unsigned MAX_CYC = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]      SHOW_LOAD = TW'(SHOW_CYCLES);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
`ifdef RPS_LOCK_TIMEOUT_EN
  localparam logic [TW-1:0]      TO_LOAD   = TW'(TIMEOUT_CYCLES);
`endif

  state_e             state_q, state_d;
  logic [2:0]         p1_hid_q, p1_hid_d, p2_hid_q, p2_hid_d;
  logic               p1_lk_q, p1_lk_d, p2_lk_q, p2_lk_d;
  logic [2:0]         result_q, result_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] p1_sc_q, p1_sc_d, p2_sc_q, p2_sc_d;
  logic [7:0]         rnd_q, rnd_d;
  logic [2:0]         verdict;
  logic               tmr_clear, tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]      tmr_val;
`ifdef RPS_LOCK_TIMEOUT_EN
  logic               ff_q, ff_d;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign verdict = norm_verdict(judge_y);

  rps_hold_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, lock capture, scoring and timer control; new_game wins over all.
  always_comb begin
    state_d   = state_q;
    p1_hid_d  = p1_hid_q;
    p2_hid_d  = p2_hid_q;
    p1_lk_d   = p1_lk_q;
    p2_lk_d   = p2_lk_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    p1_sc_d   = p1_sc_q;
    p2_sc_d   = p2_sc_q;
    rnd_d     = rnd_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = SHOW_LOAD;
`ifdef RPS_LOCK_TIMEOUT_EN
    ff_d      = ff_q;
`endif
    if (new_game) begin
      state_d   = ST_WAIT;
      p1_lk_d   = 1'b0;
      p2_lk_d   = 1'b0;
      p1_sc_d   = '0;
      p2_sc_d   = '0;
      rnd_d     = '0;
      result_d  = VERD_INVALID;
      tmr_clear = 1'b1;
`ifdef RPS_LOCK_TIMEOUT_EN
      ff_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (p1_lock && !p1_lk_q) begin
            p1_hid_d = p1_sel;
            p1_lk_d  = 1'b1;
          end
          if (p2_lock && !p2_lk_q) begin
            p2_hid_d = p2_sel;
            p2_lk_d  = 1'b1;
          end
          if (p1_lk_d && p2_lk_d) begin
            state_d = ST_EVAL;
          end
`ifdef RPS_LOCK_TIMEOUT_EN
          else if (p1_lk_d != p1_lk_q || p2_lk_d != p2_lk_q) begin
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
          end else if (p1_lk_q ^ p2_lk_q) begin
            tmr_en = 1'b1;
            if (tmr_done) begin
              // Forfeit: the absent player's move shows as NONE during SHOW.
              if (p1_lk_q) begin
                result_d = VERD_P1_WIN;
                p1_sc_d  = p1_sc_q + SCORE_W'(1);
                p2_hid_d = MOVE_NONE;
              end else begin
                result_d = VERD_P2_WIN;
                p2_sc_d  = p2_sc_q + SCORE_W'(1);
                p1_hid_d = MOVE_NONE;
              end
              rnd_d    = sat_inc(rnd_q);
              ff_d     = 1'b1;
              valid_d  = 1'b1;
              p1_lk_d  = 1'b0;
              p2_lk_d  = 1'b0;
              tmr_load = 1'b1;
              tmr_val  = SHOW_LOAD;
              state_d  = ST_SHOW;
            end
          end
`endif
        end
        ST_EVAL: begin
          result_d = verdict;
          valid_d  = 1'b1;
          p1_lk_d  = 1'b0;
          p2_lk_d  = 1'b0;
`ifdef RPS_LOCK_TIMEOUT_EN
          ff_d     = 1'b0;
`endif
          case (verdict)
            VERD_P1_WIN: begin
              p1_sc_d = p1_sc_q + SCORE_W'(1);
              rnd_d   = sat_inc(rnd_q);
            end
            VERD_P2_WIN: begin
              p2_sc_d = p2_sc_q + SCORE_W'(1);
              rnd_d   = sat_inc(rnd_q);
            end
            VERD_TIE: rnd_d = sat_inc(rnd_q);
            default: ;
          endcase
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
          state_d  = ST_SHOW;
        end
        ST_SHOW: begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            state_d = (p1_sc_q == WIN_VAL || p2_sc_q == WIN_VAL) ? ST_OVER : ST_WAIT;
          end
        end
        ST_OVER: ;
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      p1_hid_q <= MOVE_NONE;
      p2_hid_q <= MOVE_NONE;
      p1_lk_q  <= 1'b0;
      p2_lk_q  <= 1'b0;
      result_q <= VERD_INVALID;
      valid_q  <= 1'b0;
      p1_sc_q  <= '0;
      p2_sc_q  <= '0;
      rnd_q    <= '0;
    end else begin
      state_q  <= state_d;
      p1_hid_q <= p1_hid_d;
      p2_hid_q <= p2_hid_d;
      p1_lk_q  <= p1_lk_d;
      p2_lk_q  <= p2_lk_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      p1_sc_q  <= p1_sc_d;
      p2_sc_q  <= p2_sc_d;
      rnd_q    <= rnd_d;
    end
  end

`ifdef RPS_LOCK_TIMEOUT_EN
  // Forfeit flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else        ff_q <= ff_d;
  end
  assign forfeit = ff_q;
`else
  assign forfeit = 1'b0;
`endif

  assign p1_move      = (state_q == ST_EVAL || state_q == ST_SHOW) ? p1_hid_q : MOVE_NONE;
  assign p2_move      = (state_q == ST_EVAL || state_q == ST_SHOW) ? p2_hid_q : MOVE_NONE;
  assign last_result  = result_q;
  assign result_valid = valid_q;
  assign p1_score     = p1_sc_q;
  assign p2_score     = p2_sc_q;
  assign round_cnt    = rnd_q;
  assign game_over    = (state_q == ST_OVER);
  assign state_o      = state_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Scoreboard bench for rps_round_ctrl with a behavioural judge alongside.
module tb_rps_round_ctrl;

  localparam int unsigned SHOW = 4;
  localparam int unsigned WIN  = 3;
  localparam int unsigned TO   = 10;

  localparam logic [2:0] ROCK = 3'b110, PAPER = 3'b101, SCIS = 3'b011, NONE = 3'b111;

  typedef struct packed {
    logic [2:0] res;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [7:0] rnd;
    logic       ff;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [2:0] p1_sel = NONE, p2_sel = NONE;
  logic       p1_lock = 1'b0, p2_lock = 1'b0, new_game = 1'b0;
  logic [2:0] judge_y;
  logic [2:0] p1_move, p2_move, last_result;
  logic       result_valid, forfeit, game_over;
  logic [3:0] p1_score, p2_score;
  logic [7:0] round_cnt;
  logic [1:0] state_o;
  logic       ovr_en = 1'b0;
  logic [2:0] ovr_val = 3'b000;

  exp_t q[$];
  exp_t mon_e;
  exp_t rst_e;
  int   n_total = 0, n_pass = 0;

  rps_round_ctrl #(.WIN_SCORE(WIN), .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .p1_sel(p1_sel), .p2_sel(p2_sel),
    .p1_lock(p1_lock), .p2_lock(p2_lock), .new_game(new_game), .judge_y(judge_y),
    .p1_move(p1_move), .p2_move(p2_move), .last_result(last_result),
    .result_valid(result_valid), .forfeit(forfeit), .p1_score(p1_score),
    .p2_score(p2_score), .round_cnt(round_cnt), .game_over(game_over), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic legal(input logic [2:0] m);
    return (m == ROCK || m == PAPER || m == SCIS);
  endfunction

  function automatic logic [2:0] judge(input logic [2:0] a, input logic [2:0] b);
    if (!legal(a) || !legal(b)) return 3'b100;
    if (a == b) return 3'b010;
    if ((a == ROCK && b == SCIS) || (a == PAPER && b == ROCK) || (a == SCIS && b == PAPER))
      return 3'b000;
    return 3'b001;
  endfunction

  assign judge_y = ovr_en ? ovr_val : judge(p1_move, p2_move);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: got no event required event within bound", nm);
  endtask

  // Monitor: every result_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result_valid: got pulse required none");
      end else begin
        mon_e = q.pop_front();
        chk("last_result", 32'(last_result), 32'(mon_e.res));
        chk("p1_score", 32'(p1_score), 32'(mon_e.p1));
        chk("p2_score", 32'(p2_score), 32'(mon_e.p2));
        chk("round_cnt", 32'(round_cnt), 32'(mon_e.rnd));
        chk("forfeit", 32'(forfeit), 32'(mon_e.ff));
      end
    end
  end

  task automatic lock(input logic do1, input logic [2:0] s1, input logic do2, input logic [2:0] s2);
    @(negedge clk);
    if (do1) p1_sel = s1;
    if (do2) p2_sel = s2;
    p1_lock = do1;
    p2_lock = do2;
    @(negedge clk);
    p1_lock = 1'b0;
    p2_lock = 1'b0;
  endtask

  task automatic wait_result(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("wait_result_valid");
  endtask

  // Called in the EVAL cycle: checks EVAL, result, SHOW length and exit state.
  task automatic finish_round(input logic [2:0] s1, input logic [2:0] s2, input logic [1:0] nxt);
    int len;
    chk("eval_state", 32'(state_o), 32'd1);
    chk("eval_p1_move", 32'(p1_move), 32'(s1));
    chk("eval_p2_move", 32'(p2_move), 32'(s2));
    wait_result(20);
    len = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state_o == 2'd2) len++;
      else break;
    end
    chk("show_len", 32'(len), 32'(SHOW));
    chk("post_show_state", 32'(state_o), 32'(nxt));
  endtask

  task automatic play(input logic [2:0] s1, input logic [2:0] s2, input bit same,
                      input exp_t e, input logic [1:0] nxt);
    q.push_back(e);
    if (same) begin
      lock(1'b1, s1, 1'b1, s2);
    end else begin
      lock(1'b1, s1, 1'b0, NONE);
      chk("hidden_p1_move", 32'(p1_move), 32'(NONE));
      lock(1'b0, NONE, 1'b1, s2);
    end
    finish_round(s1, s2, nxt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_p1_move", 32'(p1_move), 32'(NONE));
    chk("rst_p2_move", 32'(p2_move), 32'(NONE));
    chk("rst_last_result", 32'(last_result), 32'd4);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_forfeit", 32'(forfeit), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_scores", 32'({p1_score, p2_score}), 32'd0);
    chk("rst_round_cnt", 32'(round_cnt), 32'd0);

    play(ROCK, SCIS, 1'b0, exp_t'{3'b000, 4'd1, 4'd0, 8'd1, 1'b0}, 2'd0);
    play(PAPER, PAPER, 1'b1, exp_t'{3'b010, 4'd1, 4'd0, 8'd2, 1'b0}, 2'd0);
    play(3'b100, ROCK, 1'b0, exp_t'{3'b100, 4'd1, 4'd0, 8'd2, 1'b0}, 2'd0);
    ovr_en = 1'b1;
    ovr_val = 3'b011;
    play(ROCK, ROCK, 1'b0, exp_t'{3'b100, 4'd1, 4'd0, 8'd2, 1'b0}, 2'd0);
    ovr_en = 1'b0;

    play(ROCK, PAPER, 1'b0, exp_t'{3'b001, 4'd1, 4'd1, 8'd3, 1'b0}, 2'd0);
    play(SCIS, ROCK, 1'b1, exp_t'{3'b001, 4'd1, 4'd2, 8'd4, 1'b0}, 2'd0);
    play(PAPER, SCIS, 1'b0, exp_t'{3'b001, 4'd1, 4'd3, 8'd5, 1'b0}, 2'd3);
    chk("game_over", 32'(game_over), 32'd1);
    lock(1'b1, ROCK, 1'b1, PAPER);
    repeat (10) @(negedge clk);
    chk("over_ignores_locks", 32'(state_o), 32'd3);
    chk("over_moves_hidden", 32'(p1_move), 32'(NONE));

    // new_game together with both locks: the clear wins, nothing is captured.
    @(negedge clk);
    new_game = 1'b1;
    p1_lock = 1'b1;
    p2_lock = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    p1_lock = 1'b0;
    p2_lock = 1'b0;
    chk("ng_state", 32'(state_o), 32'd0);
    chk("ng_scores", 32'({p1_score, p2_score}), 32'd0);
    chk("ng_round_cnt", 32'(round_cnt), 32'd0);
    chk("ng_last_result", 32'(last_result), 32'd4);
    chk("ng_game_over", 32'(game_over), 32'd0);
    repeat (3) @(negedge clk);
    chk("ng_priority_no_eval", 32'(state_o), 32'd0);

`ifdef RPS_LOCK_TIMEOUT_EN
    begin
      int lat;
      bit seen;
      q.push_back(exp_t'{3'b001, 4'd0, 4'd1, 8'd1, 1'b1});
      lock(1'b0, NONE, 1'b1, PAPER);
      lat = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        lat++;
        if (result_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) fail_now("timeout_result");
      chk("timeout_latency", 32'(lat), 32'(TO));
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (state_o != 2'd2) break;
      end
      chk("timeout_post_state", 32'(state_o), 32'd0);
    end
    play(ROCK, SCIS, 1'b0, exp_t'{3'b000, 4'd1, 4'd1, 8'd2, 1'b0}, 2'd0);
    rst_e = exp_t'{3'b000, 4'd2, 4'd1, 8'd3, 1'b0};
`else
    lock(1'b0, NONE, 1'b1, PAPER);
    repeat (30) @(negedge clk);
    chk("no_timeout_wait", 32'(state_o), 32'd0);
    chk("no_timeout_forfeit", 32'(forfeit), 32'd0);
    q.push_back(exp_t'{3'b001, 4'd0, 4'd1, 8'd1, 1'b0});
    lock(1'b1, ROCK, 1'b0, NONE);
    finish_round(ROCK, PAPER, 2'd0);
    rst_e = exp_t'{3'b000, 4'd1, 4'd1, 8'd2, 1'b0};
`endif

    // Asynchronous reset in the middle of SHOW.
    q.push_back(rst_e);
    lock(1'b1, ROCK, 1'b0, NONE);
    lock(1'b0, NONE, 1'b1, SCIS);
    wait_result(20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_moves", 32'({p1_move, p2_move}), 32'({NONE, NONE}));
    chk("arst_last_result", 32'(last_result), 32'd4);
    chk("arst_result_valid", 32'(result_valid), 32'd0);
    chk("arst_scores", 32'({p1_score, p2_score}), 32'd0);
    chk("arst_round_cnt", 32'(round_cnt), 32'd0);
    chk("arst_forfeit_over", 32'({forfeit, game_over}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    play(PAPER, ROCK, 1'b0, exp_t'{3'b000, 4'd1, 4'd0, 8'd1, 1'b0}, 2'd0);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Round controller for the rock-paper-scissors game; the producing and consuming end of the judge interface. Captures each player's locked-in move, hides both moves until both are locked, presents them to the combinational judge, and registers the judge's verdict. Keeps the score and round count, and holds each result for display. Declares game over when a player reaches the winning score.

## Interface
- `WIN_SCORE`, default 3: rounds a player must win to end the game (1..15).
- `SHOW_CYCLES`, default 50_000_000: cycles a result is held before the next round opens (≥1).
- `TIMEOUT_CYCLES`, default 250_000_000: lock timeout length, used only with the configuration macro (≥1).

- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `p1_sel` in 3: player 1 choice, one-hot-cold (exactly one bit 0).
- `p2_sel` in 3: player 2 choice, one-hot-cold.
- `p1_lock`, `p2_lock` in 1: single-cycle, debounced, synchronous lock pulses.
- `new_game` in 1: single-cycle pulse that clears the game.
- `judge_y` in 3: verdict from the judge.
- `p1_move`, `p2_move` out 3: moves driven to the judge.
- `last_result` out 3: registered verdict of the latest round.
- `result_valid` out 1: one-cycle pulse when `last_result` updates.
- `forfeit` out 1: latest round was decided by timeout.
- `p1_score`, `p2_score` out 4: wins this game.
- `round_cnt` out 8: decided rounds this game, saturates at 255.
- `game_over` out 1: high while in OVER.
- `state_o` out 2: current state for display.

## Operation
- Move codes:
  - ROCK 3'b110, PAPER 3'b101, SCISSORS 3'b011.
  - NONE 3'b111 is invalid and causes the judge to return INVALID.
- Verdict codes:
  - P1_WIN 3'b000, P2_WIN 3'b001, TIE 3'b010, INVALID 3'b100.
  - Any other code is treated as INVALID.
- States are WAIT, EVAL, SHOW, OVER.
- WAIT:
  - A lock pulse captures that player's `*_sel` into a hidden register and sets the player's locked flag.
  - Further locks from an already-locked player are ignored.
  - `p1_move`/`p2_move` drive NONE.
  - When both flags are set (including both pulses in the same cycle), go to EVAL next cycle.
- EVAL, exactly one cycle:
  - Drive the captured moves to the judge.
  - Sample `judge_y` at the end of the cycle into `last_result`.
  - Clear the locked flags and go to SHOW.
- Score update on the EVAL→SHOW edge:
  - P1_WIN: increment `p1_score` and `round_cnt`.
  - P2_WIN: increment `p2_score` and `round_cnt`.
  - TIE: increment `round_cnt` only.
  - INVALID: no counter changes; the round replays.
- SHOW:
  - Hold for SHOW_CYCLES cycles with `p1_move`/`p2_move` still driving the captured moves, so the display can show both.
  - Locks are ignored.
  - At the end, go to OVER if either score equals WIN_SCORE, otherwise go to WAIT.
- OVER: all locks are ignored; stay until `new_game`.
- `new_game` in any state:
  - Clears scores, `round_cnt`, locked flags, `forfeit` and the timer.
  - Sets `last_result` to INVALID.
  - Enters WAIT next cycle.
  - It has priority over every other event in that cycle.

## Timing
- Reset values:
  - State is WAIT.
  - `p1_move` = `p2_move` = 3'b111.
  - `last_result` = 3'b100.
  - `result_valid`, `forfeit` and `game_over` = 0.
  - Scores and `round_cnt` = 0.
  - `state_o` = 0.
- Latency: from the cycle the second lock pulse is sampled, EVAL occurs in the next cycle.
  - `last_result` and `result_valid` appear one cycle after EVAL.
  - The score update is visible in the same cycle as `last_result`.
- `result_valid` is high for exactly one cycle, the first SHOW cycle.
- SHOW occupies exactly SHOW_CYCLES cycles, then WAIT or OVER.
- If `rst_n` is asserted mid-round, every register goes immediately to its reset value and the partial round is discarded.

## Configuration
- `RPS_LOCK_TIMEOUT_EN` defined:
  - In WAIT, when exactly one player is locked, a timer counts cycles.
  - When it reaches TIMEOUT_CYCLES with the other player still unlocked, the locked player wins by forfeit: `last_result` becomes P1_WIN or P2_WIN, that score and `round_cnt` increment, `forfeit` goes high, `result_valid` pulses, and the block enters SHOW.
  - EVAL is skipped.
  - `forfeit` clears on the next EVAL or `new_game`.
  - The timer clears whenever the locked set changes.
- Not defined: no timer logic is generated, WAIT waits indefinitely, and `forfeit` is tied to 0.

## Structure
- Shared package `rps_pkg` holds:
  - The move constants and verdict constants.
  - The state enum.
  - The `SCORE_W = 4` constant.
- Sub-module `rps_hold_timer`:
  - A loadable down-counter with a `done` pulse.
  - Used for the SHOW hold and, when the macro is enabled, the lock timeout.
- The judge is instantiated beside this block by the top level, not inside it.

## Test plan
- P1 locks ROCK and P2 locks SCISSORS, with the judge returning 000 → `last_result` = 000, `p1_score` = 1, `round_cnt` = 1, one `result_valid` pulse, and SHOW lasts SHOW_CYCLES cycles.
- Both lock PAPER in the same cycle → EVAL on the next cycle, `last_result` = 010, `round_cnt` = 1, scores unchanged.
- P1 locks 3'b100 (invalid) → `last_result` = 100, all counters unchanged, returns to WAIT.
- P2 wins three rounds with WIN_SCORE = 3 → `game_over` = 1 and locks are ignored; then `new_game` → scores 0, WAIT.
- With the macro enabled and TIMEOUT_CYCLES = 10: only P2 locks → after 10 cycles `last_result` = 001, `forfeit` = 1, `p2_score` = 1. With the macro disabled → block stays in WAIT.
- `rst_n` low during SHOW → all outputs at reset values asynchronously; a re-locked round scores from zero.
